// File: rtl/calc_sequencer.sv
// Sequencer for the switch calculator: debounced key presses start one
// add / subtract / shift-add multiply, and the magnitude is converted to BCD
// by an iterative double-dabble before the outputs update for one VALID pulse.
module calc_sequencer #(
    parameter int W           = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    input  logic [2*W-1:0]   SW,
    input  logic [2:0]       KEY,
    output logic [2*W-1:0]   RESULT,
    output logic             NEG,
    output logic [3:0]       BCD0,
    output logic [3:0]       BCD1,
    output logic [3:0]       BCD2,
    output logic [3:0]       BCD3,
    output logic             BUSY,
    output logic             VALID
);

    localparam int RW = 2 * W;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam logic [3:0] MUL_LAST  = 4'(W - 1);
    localparam logic [3:0] CONV_LAST = 4'(RW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_reg;
    logic [2:0]      key_synced;
    logic [2:0]      key_prev_reg;
    logic [2:0]      press;
    logic            start;
    logic [1:0]      op_sel;
    logic [1:0]      op_reg;
    logic [RW-1:0]   mcand_reg;      // A, shifted left once per multiply cycle
    logic [W-1:0]    mplier_reg;     // B, shifted right once per multiply cycle
    logic [RW-1:0]   acc_reg;
    logic [RW-1:0]   acc_next;
    logic [RW-1:0]   b_ext;
    logic [RW-1:0]   calc_mag;
    logic            calc_neg;
    logic            calc_last;
    logic [3:0]      cnt_reg;
    logic [RW-1:0]   mag_reg;        // magnitude kept for RESULT
    logic [RW-1:0]   shift_reg;      // magnitude consumed MSB-first by the converter
    logic            neg_reg;
    logic [11:0]     bcd_work_reg;
    logic [7:0]      bcd_adj;
    logic [11:0]     bcd_shift;

    genvar gi;

    // Two-or-more flop synchronizer per key bit, idling high (released)
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            // shift the raw key level through this bit's synchronizer chain
            always_ff @(posedge CLOCK_50 or negedge RST_N) begin
                if (!RST_N) begin
                    chain_reg <= '1;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], KEY[gi]};
                end
            end

            assign key_synced[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    // previous synced level, for falling-edge detection
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            key_prev_reg <= '1;
        end else begin
            key_prev_reg <= key_synced;
        end
    end

    assign press = key_prev_reg & ~key_synced;
    assign start = |press;

    // fixed priority among coincident presses: add, then subtract, then multiply
    always_comb begin
        op_sel = OP_MUL;
        if (press[0]) begin
            op_sel = OP_ADD;
        end else if (press[1]) begin
            op_sel = OP_SUB;
        end
    end

    // arithmetic for the CALC state; multiply finishes on its W-th cycle
    always_comb begin
        b_ext     = {{W{1'b0}}, mplier_reg};
        acc_next  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        calc_mag  = acc_next;
        calc_neg  = 1'b0;
        calc_last = 1'b1;
        case (op_reg)
            OP_ADD: calc_mag = mcand_reg + b_ext;
            OP_SUB: begin
                if (mcand_reg < b_ext) begin
                    calc_mag = b_ext - mcand_reg;
                    calc_neg = 1'b1;
                end else begin
                    calc_mag = mcand_reg - b_ext;
                end
            end
            default: calc_last = (cnt_reg == MUL_LAST);
        endcase
    end

    // add-3 correction on the ones and tens nibbles; the hundreds nibble never
    // needs it because every result stays below 1000
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dabble
            assign bcd_adj[gi*4 +: 4] = (bcd_work_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_work_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_work_reg[gi*4 +: 4];
        end
    endgenerate

    assign bcd_shift = {bcd_work_reg[10:8], bcd_adj, shift_reg[RW-1]};

    // main sequencer: latch, compute, convert, publish
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= IDLE;
            op_reg       <= OP_ADD;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            mag_reg      <= '0;
            shift_reg    <= '0;
            neg_reg      <= 1'b0;
            bcd_work_reg <= '0;
            RESULT       <= '0;
            NEG          <= 1'b0;
            BCD0         <= '0;
            BCD1         <= '0;
            BCD2         <= '0;
            BCD3         <= '0;
            BUSY         <= 1'b0;
            VALID        <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (state_reg)
                IDLE: begin
                    BUSY <= 1'b0;
                    if (start) begin
                        mcand_reg  <= {{W{1'b0}}, SW[RW-1:W]};
                        mplier_reg <= SW[W-1:0];
                        op_reg     <= op_sel;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        BUSY       <= 1'b1;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    if (op_reg == OP_MUL) begin
                        acc_reg    <= acc_next;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        cnt_reg    <= cnt_reg + 4'd1;
                    end
                    if (calc_last) begin
                        mag_reg      <= calc_mag;
                        shift_reg    <= calc_mag;
                        neg_reg      <= calc_neg;
                        bcd_work_reg <= '0;
                        cnt_reg      <= '0;
                        state_reg    <= CONV;
                    end
                end
                CONV: begin
                    bcd_work_reg <= bcd_shift;
                    shift_reg    <= shift_reg << 1;
                    cnt_reg      <= cnt_reg + 4'd1;
                    if (cnt_reg == CONV_LAST) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    RESULT    <= mag_reg;
                    NEG       <= neg_reg;
                    BCD0      <= bcd_work_reg[3:0];
                    BCD1      <= bcd_work_reg[7:4];
                    BCD2      <= bcd_work_reg[11:8];
                    BCD3      <= neg_reg ? 4'd10 : 4'd0;
                    VALID     <= 1'b1;
                    BUSY      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    BUSY      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: directed table, hand-written reset sequence,
// and random operations checked against an arithmetic model.
module tb_calc_sequencer;

    localparam int W = 5;

    logic           CLOCK_50 = 1'b0;
    logic           RST_N;
    logic [2*W-1:0] SW;
    logic [2:0]     KEY;
    logic [2*W-1:0] RESULT;
    logic           NEG;
    logic [3:0]     BCD0, BCD1, BCD2, BCD3;
    logic           BUSY;
    logic           VALID;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    calc_sequencer #(.W(W), .SYNC_STAGES(2)) dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .SW       (SW),
        .KEY      (KEY),
        .RESULT   (RESULT),
        .NEG      (NEG),
        .BCD0     (BCD0),
        .BCD1     (BCD1),
        .BCD2     (BCD2),
        .BCD3     (BCD3),
        .BUSY     (BUSY),
        .VALID    (VALID)
    );

    typedef struct {
        int         a;
        int         b;
        logic [2:0] mask;
        int         hold;
        bit         disturb;
        int         res;
        bit         neg;
        int         busy;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [26:0] outs();
        return {RESULT, NEG, BCD3, BCD2, BCD1, BCD0};
    endfunction

    function automatic logic [15:0] exp_bcd(input int r, input bit n);
        return {(n ? 4'd10 : 4'd0), 4'(r / 100 % 10), 4'(r / 10 % 10), 4'(r % 10)};
    endfunction

    // Reference: the lowest-numbered pressed key wins; plain integer arithmetic.
    function automatic void model(input int a, input int b, input logic [2:0] mask,
                                  output int r, output bit n, output int busy);
        n = 1'b0;
        if (mask[0]) begin
            r = a + b;
            busy = 1 + 2 * W + 1;
        end else if (mask[1]) begin
            r = (a < b) ? b - a : a - b;
            n = (a < b);
            busy = 1 + 2 * W + 1;
        end else begin
            r = a * b;
            busy = W + 2 * W + 1;
        end
    endfunction

    // Press keys in mask for `hold` cycles, watch one operation, check it.
    task automatic run_op(input int a, input int b, input logic [2:0] mask, input int hold,
                          input bit disturb, input int exp_res, input bit exp_neg,
                          input int exp_busy);
        logic [26:0] snap;
        logic [26:0] got;
        int busy_cnt;
        int vcnt;
        bit moved;
        got = '0;
        busy_cnt = 0;
        vcnt = 0;
        moved = 1'b0;
        @(negedge CLOCK_50);
        snap = outs();
        SW  = {5'(a), 5'(b)};
        KEY = ~mask;
        for (int i = 0; i < hold + 40; i++) begin
            @(negedge CLOCK_50);
            if (i + 1 == hold) KEY = 3'b111;
            if (disturb && busy_cnt == 3) begin
                KEY = 3'b110;
                SW  = 10'($urandom);
            end
            if (disturb && busy_cnt == 8) KEY = 3'b111;
            if (VALID) begin
                if (vcnt == 0) got = outs();
                vcnt++;
            end else if (vcnt == 0) begin
                if (BUSY) busy_cnt++;
                if (outs() !== snap) moved = 1'b1;
            end
        end
        KEY = 3'b111;
        $display("op a=%0d b=%0d keys=%b hold=%0d -> result=%0d neg=%0d bcd=%0d,%0d,%0d,%0d busy=%0d valids=%0d",
                 a, b, mask, hold, got[26:17], got[16], got[15:12], got[11:8], got[7:4],
                 got[3:0], busy_cnt, vcnt);
        chk("valid_count", vcnt, 1);
        chk("result", got[26:17], exp_res);
        chk("neg", got[16], exp_neg);
        chk("bcd", got[15:0], exp_bcd(exp_res, exp_neg));
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("outputs_held_while_busy", moved, 0);
    endtask

    initial begin
        int r, bc, vc, ra, rb, rhold, rbusy;
        bit rn;
        logic [2:0] rmask;

        tbl[0] = '{a: 12, b: 7,  mask: 3'b001, hold: 3,   disturb: 0, res: 19,  neg: 0, busy: 12};
        tbl[1] = '{a: 3,  b: 20, mask: 3'b010, hold: 3,   disturb: 0, res: 17,  neg: 1, busy: 12};
        tbl[2] = '{a: 9,  b: 9,  mask: 3'b010, hold: 3,   disturb: 0, res: 0,   neg: 0, busy: 12};
        tbl[3] = '{a: 31, b: 31, mask: 3'b100, hold: 3,   disturb: 0, res: 961, neg: 0, busy: 16};
        tbl[4] = '{a: 0,  b: 25, mask: 3'b100, hold: 3,   disturb: 0, res: 0,   neg: 0, busy: 16};
        tbl[5] = '{a: 4,  b: 5,  mask: 3'b101, hold: 3,   disturb: 0, res: 9,   neg: 0, busy: 12};
        tbl[6] = '{a: 6,  b: 7,  mask: 3'b100, hold: 3,   disturb: 1, res: 42,  neg: 0, busy: 16};

        RST_N = 1'b0;
        SW    = '0;
        KEY   = 3'b111;
        repeat (3) @(negedge CLOCK_50);
        chk("reset_outputs", outs(), 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_valid", VALID, 0);
        RST_N = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        for (int t = 0; t < 7; t++) begin
            run_op(tbl[t].a, tbl[t].b, tbl[t].mask, tbl[t].hold, tbl[t].disturb,
                   tbl[t].res, tbl[t].neg, tbl[t].busy);
        end

        // key held low for 100 cycles produces a single operation
        run_op(4, 5, 3'b001, 100, 0, 9, 0, 12);

        // reset in the middle of conversion of 31*31
        run_op(12, 7, 3'b001, 3, 0, 19, 0, 12);
        @(negedge CLOCK_50);
        SW  = {5'd31, 5'd31};
        KEY = 3'b011;
        bc  = 0;
        for (int i = 0; i < 60 && bc < W + 3; i++) begin
            @(negedge CLOCK_50);
            if (i == 2) KEY = 3'b111;
            if (BUSY) bc++;
        end
        KEY = 3'b111;
        chk("reached_conv", bc, W + 3);
        #2 RST_N = 1'b0;
        #1;
        $display("op mid-conversion reset -> result=%0d busy=%0d valid=%0d", RESULT, BUSY, VALID);
        chk("midreset_outputs", outs(), 0);
        chk("midreset_busy", BUSY, 0);
        chk("midreset_valid", VALID, 0);
        repeat (3) @(negedge CLOCK_50);
        RST_N = 1'b1;
        vc = 0;
        repeat (30) begin
            @(negedge CLOCK_50);
            if (VALID) vc++;
        end
        chk("no_valid_after_reset", vc, 0);
        run_op(1, 1, 3'b001, 2, 0, 2, 0, 12);

        // random operations against the arithmetic model
        for (int k = 0; k < 25; k++) begin
            ra    = $urandom_range(0, 31);
            rb    = $urandom_range(0, 31);
            rmask = 3'($urandom_range(1, 7));
            rhold = $urandom_range(1, 6);
            model(ra, rb, rmask, r, rn, rbusy);
            run_op(ra, rb, rmask, rhold, 0, r, rn, rbusy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
